// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned shift-add multiplier driving an external
// combinational adder. One accumulate-and-shift step per clock; a full
// 2*WIDTH-bit product is produced WIDTH cycles after an accepted start.
//
// Ports:
//   clock    - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - request a multiply (sampled only while not busy)
//   a_in     - multiplicand, captured on accepted start
//   b_in     - multiplier, captured on accepted start
//   busy     - iteration in progress (registered)
//   valid    - one-cycle pulse: product newly updated (registered)
//   product  - last completed result, held until the next completion
//   add_a    - adder operand a (accumulator high half)
//   add_b    - adder operand b (multiplicand when multiplier LSB is set, else 0)
//   add_sum  - adder sum
//   add_c    - adder carry-out
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_c
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_next;

  // Operands come from registers only, so there is no loop through the adder.
  assign add_a = hi_q;
  assign add_b = lo_q[0] ? mcand_q : '0;

  // The (WIDTH+1)-bit sum shifted right one place into the accumulator; the
  // carry lands in the MSB so nothing is lost.
  assign acc_next = {add_c, add_sum, lo_q[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            hi_q    <= '0;
            lo_q    <= b_in;
            mcand_q <= a_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          {hi_q, lo_q} <= acc_next;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            product <= acc_next;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  localparam int unsigned WIDTH = 32;

  logic               clock;
  logic               reset_n;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_c;

  int tests;
  int fails;

  // Attached combinational adder.
  assign {add_c, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  mul_seq #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .valid   (valid),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .add_c   (add_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present operands and start for exactly one edge (edge N), return 1ns after it.
  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a_in  = '1;
    b_in  = '1;
  endtask

  // Start a multiply and measure latency (edges after start edge to valid),
  // number of cycles busy was observed high, and the resulting product.
  task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int bcyc, output logic [2*WIDTH-1:0] prod);
    do_start(a, b);
    bcyc = busy ? 1 : 0;
    lat  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (valid) begin
        lat = k;
        break;
      end
      if (busy) bcyc++;
    end
    prod = product;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    #12;
    tests++;
    if ({busy, valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags: busy=%b valid=%b required 0 0", busy, valid);
    end
    tests++;
    if (product !== '0) begin
      fails++;
      $display("FAIL reset_product: got %h required 0", product);
    end
    tests++;
    if (add_a !== '0 || add_b !== '0) begin
      fails++;
      $display("FAIL reset_adder_ops: add_a=%h add_b=%h required 0 0", add_a, add_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    int lat, bcyc;
    logic [2*WIDTH-1:0] prod;
    run_mult(32'd3, 32'd5, lat, bcyc, prod);
    tests++;
    if (lat !== 32) begin
      fails++;
      $display("FAIL basic_latency: got %0d required 32", lat);
    end
    tests++;
    if (bcyc !== 32) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d required 32", bcyc);
    end
    tests++;
    if (prod !== 64'd15) begin
      fails++;
      $display("FAIL basic_product: got %h required %h", prod, 64'd15);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_in_valid: got %b required 0", busy);
    end
    @(posedge clock);
    #1;
    tests++;
    if (valid !== 1'b0 || product !== 64'd15) begin
      fails++;
      $display("FAIL basic_valid_pulse: valid=%b product=%h required 0 %h",
               valid, product, 64'd15);
    end
  endtask

  task automatic test_carry;
    int lat, bcyc;
    logic [2*WIDTH-1:0] prod;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc, prod);
    tests++;
    if (lat !== 32 || prod !== 64'hFFFF_FFFE_0000_0001) begin
      fails++;
      $display("FAIL carry_product: lat=%0d product=%h required 32 %h",
               lat, prod, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_zero_identity;
    int lat, bcyc;
    logic [2*WIDTH-1:0] prod;
    run_mult(32'd0, 32'h1234_5678, lat, bcyc, prod);
    tests++;
    if (lat !== 32 || prod !== 64'd0) begin
      fails++;
      $display("FAIL zero_product: lat=%0d product=%h required 32 0", lat, prod);
    end
    run_mult(32'd1, 32'hDEAD_BEEF, lat, bcyc, prod);
    tests++;
    if (lat !== 32 || prod !== 64'h0000_0000_DEAD_BEEF) begin
      fails++;
      $display("FAIL identity_product: lat=%0d product=%h required 32 %h",
               lat, prod, 64'h0000_0000_DEAD_BEEF);
    end
  endtask

  task automatic test_start_while_busy;
    int lat, nvalid;
    do_start(32'd3, 32'd5);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) begin
        a_in  = 32'd7;
        b_in  = 32'd9;
        start = 1'b1;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      if (valid) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat !== 32 || product !== 64'd15) begin
      fails++;
      $display("FAIL busy_start_ignored: lat=%0d product=%h required 32 %h",
               lat, product, 64'd15);
    end
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (valid || busy) nvalid++;
    end
    tests++;
    if (nvalid !== 0) begin
      fails++;
      $display("FAIL busy_start_no_extra: got %0d active cycles required 0", nvalid);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcyc, gap;
    logic [2*WIDTH-1:0] prod;
    run_mult(32'd3, 32'd5, lat, bcyc, prod);
    // Issue the second request in the valid cycle.
    a_in  = 32'h0001_0000;
    b_in  = 32'h0001_0000;
    start = 1'b1;
    gap   = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (valid) begin
        gap = k;
        break;
      end
    end
    tests++;
    if (gap !== 33) begin
      fails++;
      $display("FAIL b2b_gap: got %0d required 33", gap);
    end
    tests++;
    if (product !== 64'h0000_0001_0000_0000) begin
      fails++;
      $display("FAIL b2b_product: got %h required %h", product, 64'h0000_0001_0000_0000);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bcyc, nvalid;
    logic [2*WIDTH-1:0] prod;
    do_start(32'hFFFF_FFFF, 32'd2);
    for (int k = 1; k < 16; k++) begin
      @(posedge clock);
    end
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0 || product !== '0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b valid=%b product=%h required 0 0 0",
               busy, valid, product);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (valid || busy) nvalid++;
    end
    tests++;
    if (nvalid !== 0 || product !== '0) begin
      fails++;
      $display("FAIL midrun_no_valid: active=%0d product=%h required 0 0", nvalid, product);
    end
    run_mult(32'd6, 32'd7, lat, bcyc, prod);
    tests++;
    if (lat !== 32 || prod !== 64'd42) begin
      fails++;
      $display("FAIL midrun_recover: lat=%0d product=%h required 32 %h", lat, prod, 64'd42);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_carry();
    test_zero_identity();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential unsigned shift-add multiplier that sits directly upstream of the CPU's combinational `add` stage. It drives the adder's operand inputs and consumes its `{c, sum}` result once per cycle. It produces a full double-width product after a fixed WIDTH-cycle iteration. Issue logic uses it through a start/busy/valid handshake. It contains no adder of its own; the `add` instance is wired alongside it at the level above.

## Interface
- WIDTH, 32, operand width; must equal the width of the attached `add` instance.

- clock  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only when `busy`=0.
- a_in  in  WIDTH  multiplicand, captured on accepted start.
- b_in  in  WIDTH  multiplier, captured on accepted start.
- busy  out  1  high while an iteration is in progress.
- valid  out  1  one-cycle pulse, `product` newly updated.
- product  out  2*WIDTH  last completed result; held until the next completion.
- add_a  out  WIDTH  adder operand a; equals the accumulator high half.
- add_b  out  WIDTH  adder operand b; equals the multiplicand if multiplier LSB=1, else 0.
- add_sum  in  WIDTH  adder sum.
- add_c  in  1  adder carry-out.

## Operation
- Internal registers:
  - `hi` (WIDTH): accumulator high half.
  - `lo` (WIDTH): accumulator low half / multiplier.
  - `mcand` (WIDTH): captured multiplicand.
  - `cnt` (log2(WIDTH)+1 bits): step counter.
  - `state`: IDLE or RUN.
- The adder path is combinational: `add_a` = `hi`; `add_b` = `lo[0]` ? `mcand` : 0.
- IDLE state:
  - If `start`=1: load `hi`=0, `lo`=`b_in`, `mcand`=`a_in`, `cnt`=0, and go to RUN.
  - Otherwise hold.
- RUN state, each edge:
  - `{hi, lo}` <= `{add_c, add_sum, lo[WIDTH-1:1]}`, a right shift of the (WIDTH+1)-bit sum into the accumulator.
  - `cnt` <= `cnt`+1.
- When `cnt`=WIDTH-1 at an edge, that edge performs the final step and also:
  - loads `product` <= the post-step `{hi, lo}` value, i.e. the shifted result;
  - sets `valid`=1;
  - returns to IDLE.
- Carry is never lost: `add_c` becomes the MSB of the new `hi`. Results are exact modulo 2^(2*WIDTH), with no overflow possible.
- `start` while `busy`=1 is ignored; operands are not re-captured and there is no queueing.
- `a_in`/`b_in` may change freely after acceptance.
- `product` is not disturbed during a run; it still shows the previous result.
- Reset values, asynchronous on `reset_n`=0:
  - state IDLE;
  - `busy`=0, `valid`=0, `product`=0;
  - `hi`=`lo`=`mcand`=0, `cnt`=0.
  - As a consequence, `add_a`=0 and `add_b`=0.
- Reset mid-run aborts the operation: no `valid` is produced and `product` becomes 0.

## Timing
- Accepted start at edge N: `busy`=1 from after edge N until after edge N+WIDTH.
- Final step at edge N+WIDTH: `valid`=1 and the new `product` appear after edge N+WIDTH. `valid` stays high for exactly one cycle, dropping after edge N+WIDTH+1 unless another completion occurs.
- Latency is WIDTH cycles, start edge to result edge (32 for the default).
- `busy` is 0 during the `valid` cycle. A `start` in that cycle is accepted at edge N+WIDTH+1, so back-to-back throughput is one result per WIDTH+1 cycles.
- `busy` and `valid` are registered outputs. `add_a`/`add_b` are combinational from registers only, with no path from `add_sum` back to `add_a`/`add_b`.
- The adder's combinational delay must fit in one clock period along with register setup.

## Test plan
- Basic multiply: reset, then `start` with `a_in`=3, `b_in`=5.
  - `valid` pulses exactly 32 cycles after the start edge with `product`=15.
  - `busy` is high for exactly 32 cycles.
- Carry propagation: `a_in`=`b_in`=0xFFFFFFFF -> `product`=0xFFFFFFFE00000001. Checks that `add_c` is captured on every step.
- Zero and identity: `a_in`=0, `b_in`=0x12345678 -> `product`=0. `a_in`=1, `b_in`=0xDEADBEEF -> `product`=0x00000000DEADBEEF.
- Start while busy: pulse `start` with `a_in`=7, `b_in`=9 at cycle 10 of a 3*5 run.
  - `product`=15 at the original time.
  - No extra `valid` pulse.
- Back-to-back: assert `start` in the `valid` cycle with 0x10000*0x10000.
  - The second `valid` comes 33 cycles after the first, with `product`=0x0000000100000000.
- Reset mid-run: drop `reset_n` at cycle 16 of 0xFFFFFFFF*2.
  - Immediately `busy`=0, `valid`=0, `product`=0.
  - No `valid` follows.
  - A subsequent 6*7 yields 42.
